// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
//   - Default memory / register-file sizes and the address widths they imply.
//   - Word width of the instruction stream and memories.
//   - Loader FSM state encoding and the debug snapshot struct exported by the top.
package program_loader_pkg;

  localparam int IMEM_WORDS_DEF = 256;
  localparam int RF_REGS_DEF    = 32;
  localparam int IMEM_AW        = 8;
  localparam int RF_AW          = 5;
  localparam int WORD_W         = 32;
  localparam int RUN_CW         = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Debug snapshot of the sequencer: FSM state plus both counters.
  typedef struct packed {
    state_e              state;
    logic [IMEM_AW-1:0]  word_cnt;
    logic [RUN_CW-1:0]   run_cnt;
  } dbg_t;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_CLEAR) || (s == ST_LOAD) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/loader_counter.sv
// Parameterised up-counter used by the program loader.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-low reset, clears the count
//   clr_i   synchronous clear to zero (wins over en_i)
//   en_i    increment by one, wrapping at 2**W
//   term_i  terminal value to compare against
//   cnt_o   current count
//   tc_o    high while cnt_o equals term_i
module loader_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/program_loader.sv
// Program loader: clears instruction memory and register file, streams a
// program into instruction memory, then holds the CPU start line for a
// bounded (or unbounded) number of cycles.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   go_i, run_cycles_i      start request and run length (0 = until abort)
//   abort_i                 ends RUN early
//   load_valid_i/ready_o/data_i/last_i   instruction word stream
//   imem_we_o/addr_o/wdata_o             instruction-memory write port
//   rf_we_o/addr_o/wdata_o               register-file write port
//   cpu_start_o             CPU start strobe, high for every RUN cycle
//   busy_o, done_o, err_o   status
//   dbg_o                   state and counter snapshot
//
// Load stream handshake: a word transfers on a rising edge where both
// load_valid_i and load_ready_o are high; ready depends only on the
// registered state, never on valid, and the word is written to memory on
// the following cycle through registered write-port outputs.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int RF_REGS    = RF_REGS_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                go_i,
  input  logic [RUN_CW-1:0]   run_cycles_i,
  input  logic                abort_i,
  input  logic                load_valid_i,
  output logic                load_ready_o,
  input  logic [WORD_W-1:0]   load_data_i,
  input  logic                load_last_i,
  output logic                imem_we_o,
  output logic [IMEM_AW-1:0]  imem_addr_o,
  output logic [WORD_W-1:0]   imem_wdata_o,
  output logic                rf_we_o,
  output logic [RF_AW-1:0]    rf_addr_o,
  output logic [WORD_W-1:0]   rf_wdata_o,
  output logic                cpu_start_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output dbg_t                dbg_o
);

  localparam logic [IMEM_AW-1:0] IMEM_LAST = IMEM_AW'(IMEM_WORDS - 1);
  localparam logic [IMEM_AW-1:0] RF_LAST   = IMEM_AW'(RF_REGS - 1);

  state_e              state_d, state_q;
  logic [RUN_CW-1:0]   run_cycles_d, run_cycles_q;
  logic                err_d, err_q;
  logic                imem_we_d, imem_we_q;
  logic [IMEM_AW-1:0]  imem_addr_d, imem_addr_q;
  logic [WORD_W-1:0]   imem_wdata_d, imem_wdata_q;
  logic                rf_we_d, rf_we_q;
  logic [RF_AW-1:0]    rf_addr_d, rf_addr_q;

  // The same counter serves as the clear address in CLEAR and as the word
  // index in LOAD; it is zeroed on the CLEAR->LOAD transition.
  logic                addr_clr, addr_en, addr_tc;
  logic [IMEM_AW-1:0]  addr_cnt;
  logic                run_clr, run_en, run_tc;
  logic [RUN_CW-1:0]   run_cnt;
  logic                accept;

  loader_counter #(.W(IMEM_AW)) u_addr_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (addr_clr),
    .en_i   (addr_en),
    .term_i (IMEM_LAST),
    .cnt_o  (addr_cnt),
    .tc_o   (addr_tc)
  );

  // Terminal value is run_cycles-1 because the count starts at 0 on the
  // first RUN cycle. A run length of 0 is filtered out in the FSM.
  loader_counter #(.W(RUN_CW)) u_run_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (run_clr),
    .en_i   (run_en),
    .term_i (run_cycles_q - RUN_CW'(1)),
    .cnt_o  (run_cnt),
    .tc_o   (run_tc)
  );

  assign accept = load_valid_i && (state_q == ST_LOAD);

  always_comb begin
    state_d      = state_q;
    run_cycles_d = run_cycles_q;
    err_d        = err_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = '0;
    imem_wdata_d = '0;
    rf_we_d      = 1'b0;
    rf_addr_d    = '0;
    addr_clr     = 1'b0;
    addr_en      = 1'b0;
    run_clr      = 1'b0;
    run_en       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go_i) begin
          state_d      = ST_CLEAR;
          run_cycles_d = run_cycles_i;
          err_d        = 1'b0;
          addr_clr     = 1'b1;
          run_clr      = 1'b1;
        end
      end

      ST_CLEAR: begin
        imem_we_d   = 1'b1;
        imem_addr_d = addr_cnt;
        if (addr_cnt <= RF_LAST) begin
          rf_we_d   = 1'b1;
          rf_addr_d = addr_cnt[RF_AW-1:0];
        end
        if (addr_tc) begin
          state_d  = ST_LOAD;
          addr_clr = 1'b1;
        end else begin
          addr_en = 1'b1;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = addr_cnt;
          imem_wdata_d = load_data_i;
          addr_en      = 1'b1;
          if (load_last_i) begin
            state_d = ST_RUN;
            run_clr = 1'b1;
          end else if (addr_tc) begin
            // Memory full without an end marker: never start the CPU.
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end

      ST_RUN: begin
        run_en = 1'b1;
        if (abort_i) begin
          state_d = ST_DONE;
        end else if ((run_cycles_q != '0) && run_tc) begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      run_cycles_q <= '0;
      err_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      run_cycles_q <= run_cycles_d;
      err_q        <= err_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
    end
  end

  // Status and strobe outputs decode the state flop directly, so they drop
  // the instant reset asserts.
  assign load_ready_o = (state_q == ST_LOAD);
  assign cpu_start_o  = (state_q == ST_RUN);
  assign busy_o       = state_is_busy(state_q);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = err_q;

  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign rf_we_o      = rf_we_q;
  assign rf_addr_o    = rf_addr_q;
  // The register file is only ever cleared.
  assign rf_wdata_o   = '0;

  assign dbg_o.state    = state_q;
  assign dbg_o.word_cnt = addr_cnt;
  assign dbg_o.run_cnt  = run_cnt;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus tasks push expected memory
// and register-file writes into queues; a monitor pops them as the design
// presents writes. Directed sequences cover a normal load/run, gapped valid,
// go during LOAD, abort with unbounded run, overflow error and reset in RUN.
module tb_program_loader;
  import program_loader_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b0;
  logic                go_i = 1'b0;
  logic [RUN_CW-1:0]   run_cycles_i = '0;
  logic                abort_i = 1'b0;
  logic                load_valid_i = 1'b0;
  logic                load_ready_o;
  logic [WORD_W-1:0]   load_data_i = '0;
  logic                load_last_i = 1'b0;
  logic                imem_we_o;
  logic [IMEM_AW-1:0]  imem_addr_o;
  logic [WORD_W-1:0]   imem_wdata_o;
  logic                rf_we_o;
  logic [RF_AW-1:0]    rf_addr_o;
  logic [WORD_W-1:0]   rf_wdata_o;
  logic                cpu_start_o;
  logic                busy_o;
  logic                done_o;
  logic                err_o;
  dbg_t                dbg_o;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int start_base = 0;

  logic [IMEM_AW+WORD_W-1:0] exp_q[$];
  logic [RF_AW+WORD_W-1:0]   exp_rf_q[$];

  program_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .go_i         (go_i),
    .run_cycles_i (run_cycles_i),
    .abort_i      (abort_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_data_i  (load_data_i),
    .load_last_i  (load_last_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .rf_we_o      (rf_we_o),
    .rf_addr_o    (rf_addr_o),
    .rf_wdata_o   (rf_wdata_o),
    .cpu_start_o  (cpu_start_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .dbg_o        (dbg_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (cpu_start_o) start_cnt++;
      if (imem_we_o) begin
        if (exp_q.size() == 0) begin
          check("imem_extra_we", imem_we_o, 1'b0);
        end else begin
          check("imem_write", {imem_addr_o, imem_wdata_o}, exp_q.pop_front());
        end
      end
      if (rf_we_o) begin
        if (exp_rf_q.size() == 0) begin
          check("rf_extra_we", rf_we_o, 1'b0);
        end else begin
          check("rf_write", {rf_addr_o, rf_wdata_o}, exp_rf_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the design in IDLE or DONE.
  task automatic do_go(input logic [RUN_CW-1:0] cyc);
    go_i = 1'b1;
    run_cycles_i = cyc;
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 32'h0});
    for (int i = 0; i < 32; i++) exp_rf_q.push_back({5'(i), 32'h0});
    start_base = start_cnt;
    @(negedge clk_i);
    go_i = 1'b0;
    run_cycles_i = 16'hBEEF;
  endtask

  task automatic send_one(input int k, input logic [31:0] d, input bit last);
    int b;
    b = 0;
    while (!load_ready_o && b < 400) begin
      @(negedge clk_i);
      b++;
    end
    check("load_ready", load_ready_o, 1'b1);
    load_valid_i = 1'b1;
    load_data_i  = d;
    load_last_i  = last;
    exp_q.push_back({8'(k), d});
    @(negedge clk_i);
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
  endtask

  task automatic wait_state(input state_e st, input int budget, input string name);
    int b;
    b = 0;
    while (dbg_o.state != st && b < budget) begin
      @(negedge clk_i);
      b++;
    end
    check(name, dbg_o.state, st);
  endtask

  task automatic check_done(input int exp_starts, input logic exp_err, input string tag);
    check({tag, "_starts"}, start_cnt - start_base, exp_starts);
    check({tag, "_done"}, done_o, 1'b1);
    check({tag, "_err"}, err_o, exp_err);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_cpu_start"}, cpu_start_o, 1'b0);
    check({tag, "_imem_q_left"}, exp_q.size(), 0);
    check({tag, "_rf_q_left"}, exp_rf_q.size(), 0);
  endtask

  // ---------------- sequences ----------------
  initial begin
    int cnt;
    logic [31:0] prog [0:2];
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_state", dbg_o.state, ST_IDLE);
    check("rst_outs", {imem_we_o, imem_addr_o, imem_wdata_o, rf_we_o, rf_addr_o},
          {1'b0, 8'h0, 32'h0, 1'b0, 5'h0});
    check("rst_rf_wdata", rf_wdata_o, 32'h0);
    check("rst_status", {load_ready_o, cpu_start_o, busy_o, done_o, err_o}, 5'b0);
    check("rst_counters", {dbg_o.word_cnt, dbg_o.run_cnt}, 24'h0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Normal sequence: 3 words, run 30 cycles
    do_go(16'd30);
    check("t1_busy", busy_o, 1'b1);
    check("t1_state_clear", dbg_o.state, ST_CLEAR);
    for (int k = 0; k < 3; k++) send_one(k, prog[k], k == 2);
    wait_state(ST_DONE, 100, "t1_reach_done");
    @(negedge clk_i);
    check_done(30, 1'b0, "t1");

    // valid toggled every other cycle
    do_go(16'd5);
    for (int k = 0; k < 3; k++) begin
      send_one(k, 32'hA000_0000 + 32'(k), k == 2);
      @(negedge clk_i);
    end
    wait_state(ST_DONE, 100, "t2_reach_done");
    @(negedge clk_i);
    check_done(5, 1'b0, "t2");

    // go during LOAD is ignored, including its run length
    do_go(16'd4);
    send_one(0, 32'h1111_1111, 1'b0);
    send_one(1, 32'h2222_2222, 1'b0);
    go_i = 1'b1;
    run_cycles_i = 16'd7;
    @(negedge clk_i);
    go_i = 1'b0;
    check("t6_state_load", dbg_o.state, ST_LOAD);
    check("t6_word_cnt", dbg_o.word_cnt, 8'd2);
    send_one(2, 32'h3333_3333, 1'b1);
    wait_state(ST_DONE, 100, "t6_reach_done");
    @(negedge clk_i);
    check_done(4, 1'b0, "t6");

    // Unbounded run ended by abort after 100 cycles
    do_go(16'd0);
    send_one(0, 32'h0000_006F, 1'b1);
    wait_state(ST_RUN, 50, "t4_reach_run");
    cnt = 1;
    while (cnt < 100) begin
      @(negedge clk_i);
      if (cpu_start_o) cnt++;
    end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check("t4_state_done", dbg_o.state, ST_DONE);
    check_done(100, 1'b0, "t4");

    // 256 words without last: error, CPU never started
    do_go(16'd9);
    for (int k = 0; k < 256; k++) send_one(k, 32'h5000_0000 | 32'(k), 1'b0);
    @(negedge clk_i);
    check("t3_state_done", dbg_o.state, ST_DONE);
    check("t3_ready_low", load_ready_o, 1'b0);
    check_done(0, 1'b1, "t3");

    // go from DONE clears err; reset during RUN cycle 10
    do_go(16'd0);
    check("t5_err_cleared", err_o, 1'b0);
    check("t5_done_cleared", done_o, 1'b0);
    send_one(0, 32'h0000_0001, 1'b0);
    send_one(1, 32'h0000_0002, 1'b1);
    wait_state(ST_RUN, 50, "t5_reach_run");
    repeat (9) @(negedge clk_i);
    check("t5_in_run", cpu_start_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    check("t5_rst_cpu_start", cpu_start_o, 1'b0);
    check("t5_rst_busy", busy_o, 1'b0);
    check("t5_rst_state", dbg_o.state, ST_IDLE);
    check("t5_rst_counters", {dbg_o.word_cnt, dbg_o.run_cnt}, 24'h0);
    check("t5_rst_we", {imem_we_o, rf_we_o}, 2'b00);
    check("t5_q_left", exp_q.size() + exp_rf_q.size(), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    do_go(16'd3);
    send_one(0, 32'h0000_0073, 1'b1);
    wait_state(ST_DONE, 100, "t5b_reach_done");
    @(negedge clk_i);
    check_done(3, 1'b0, "t5b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 256, instruction-memory depth in 32-bit words.
REQ-002 Parameter RF_REGS, default 32, register-file entries to clear.
REQ-003 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  reset, asynchronous and active-low.
REQ-005 Port go_i  input  1  one-cycle request to start a clear/load/run sequence.
REQ-006 Port run_cycles_i  input  16  CPU cycles to run, sampled when go_i is accepted; 0 = unbounded.
REQ-007 Port abort_i  input  1  ends RUN early.
REQ-008 Port load_valid_i / load_ready_o / load_data_i / load_last_i  in/out/in/in  1/1/32/1  instruction word stream.
REQ-009 Port imem_we_o / imem_addr_o / imem_wdata_o  output  1/8/32  instruction-memory word write port.
REQ-010 Port rf_we_o / rf_addr_o / rf_wdata_o  output  1/5/32  register-file write port.
REQ-011 Port cpu_start_o  output  1  drives CPU start_i.
REQ-012 Port busy_o / done_o / err_o  output  1 each  status.

Function
REQ-013 FSM states IDLE, CLEAR, LOAD, RUN, DONE; busy_o = 1 in CLEAR, LOAD, RUN.
REQ-014 IDLE or DONE + go_i -> CLEAR; go_i in any other state is ignored.
REQ-015 Accepting go_i clears done_o and err_o and latches run_cycles_i.
REQ-016 CLEAR: IMEM_WORDS consecutive cycles writing 0 to imem addresses 0..IMEM_WORDS-1 ascending, one per cycle.
REQ-017 CLEAR: during its first RF_REGS cycles, also writes 0 to rf addresses 0..RF_REGS-1 ascending.
REQ-018 CLEAR -> LOAD after the write to the last imem address.
REQ-019 load_ready_o = 1 only in LOAD; a word is accepted when load_valid_i & load_ready_o.
REQ-020 Accepted word k (from 0) is written to imem address k: imem_we_o, address and data registered, one cycle after acceptance.
REQ-021 Accepting a word with load_last_i = 1 -> RUN.
REQ-022 Accepting word IMEM_WORDS-1 with load_last_i = 0 sets err_o and -> DONE; CPU is never started.
REQ-023 RUN: cpu_start_o = 1 every cycle; a 16-bit counter counts those cycles.
REQ-024 RUN -> DONE after exactly run_cycles cycles with cpu_start_o high, or the cycle after abort_i; abort_i takes priority over the count.
REQ-025 run_cycles = 0: RUN exits only on abort_i or reset.
REQ-026 DONE: done_o = 1, cpu_start_o = 0; held until the next accepted go_i.
REQ-027 imem_we_o and rf_we_o are never asserted outside CLEAR/LOAD, plus the one registered write cycle following the last accepted word.

Reset
REQ-028 rst_i low forces IDLE asynchronously, in any state.
REQ-029 During reset, all outputs are 0: addresses, data, we, ready, cpu_start_o, busy_o, done_o, err_o.
REQ-030 During reset, the word counter, clear counter and run counter are 0.
REQ-031 Reset mid-LOAD or mid-RUN drops cpu_start_o immediately; no partial word is written after reset asserts.

Structure
REQ-032 Shared package holds the state enum, IMEM_WORDS/RF_REGS defaults, address widths and the 32-bit word width constant.
REQ-033 One sub-module, loader_counter: a parameterised up-counter with clear, enable and terminal-count flag.
REQ-034 loader_counter is instanced for the clear/word address and for the run cycles.

Verification
REQ-035 Reset release, go_i, run_cycles=30, 3 words (last on 3rd) -> 256 zero imem writes, 32 zero rf writes, imem[0..2] = words, cpu_start_o high exactly 30 cycles, done_o=1.
REQ-036 load_valid_i toggled every other cycle -> words land at consecutive addresses 0,1,2 with no gaps or duplicates.
REQ-037 256 words, none with last -> err_o=1, done_o=1, cpu_start_o never asserted.
REQ-038 run_cycles=0, abort_i pulsed after 100 RUN cycles -> DONE next cycle, cpu_start_o high exactly 100 cycles.
REQ-039 rst_i low during RUN cycle 10 -> cpu_start_o and busy_o 0 asynchronously; state IDLE; go_i after release restarts with CLEAR from address 0.
REQ-040 go_i pulsed during LOAD -> ignored, word address continues unchanged.
